// File: rtl/keypad_scanner.sv
// Row/column matrix keypad scanner: one-hot column strobe, single-key debounce,
// linear or telephone decode, and optional auto-repeat while the key is held.
module keypad_scanner #(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int BASE        = 16,
  parameter int SCAN_DIV    = 1000,
  parameter int DEBOUNCE    = 8,
  parameter int REPEAT_DLY  = 0,
  parameter int REPEAT_RATE = 4,
  localparam int VW = ($clog2(ROWS * COLS) > 4) ? $clog2(ROWS * COLS) : 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS-1:0] row_sense,
  output logic [COLS-1:0] col_drive,
  output logic [VW-1:0]   key_value,
  output logic            key_valid,
  output logic            key_held,
  output logic            key_release
);

  localparam int DW   = $clog2(SCAN_DIV);
  localparam int RIW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CIW  = $clog2(COLS);
  localparam int MW   = $clog2(DEBOUNCE + 1);
  localparam int RMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam bit DEC_OK = (BASE == 16) || (BASE == 10 && ROWS == 4 && COLS == 4);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [DW-1:0]   div_cnt_reg, div_cnt_next;
  logic [COLS-1:0] col_drive_reg, col_drive_next;
  logic [CIW-1:0]  col_idx_reg, col_idx_next;
  logic [ROWS-1:0] row_pat_reg, row_pat_next;
  logic [RIW-1:0]  row_idx_reg, row_idx_next;
  logic [MW-1:0]   deb_cnt_reg, deb_cnt_next;
  logic [RW-1:0]   rep_cnt_reg, rep_cnt_next;
  logic            rep_armed_reg, rep_armed_next;
  logic [VW-1:0]   key_value_reg, key_value_next;
  logic            key_valid_reg, key_valid_next;
  logic            key_held_reg, key_held_next;
  logic            key_release_reg, key_release_next;

  logic            sample;
  logic            row_onehot;
  logic [RIW-1:0]  row_index;
  logic [VW-1:0]   decoded;
  logic            rotate, accept, repeat_fire, release_done;

  function automatic logic [3:0] phone_map(input int idx);
    case (idx)
      0:  phone_map = 4'd1;
      1:  phone_map = 4'd2;
      2:  phone_map = 4'd3;
      3:  phone_map = 4'd10;
      4:  phone_map = 4'd4;
      5:  phone_map = 4'd5;
      6:  phone_map = 4'd6;
      7:  phone_map = 4'd11;
      8:  phone_map = 4'd7;
      9:  phone_map = 4'd8;
      10: phone_map = 4'd9;
      11: phone_map = 4'd12;
      12: phone_map = 4'd14;
      13: phone_map = 4'd0;
      14: phone_map = 4'd15;
      15: phone_map = 4'd13;
      default: phone_map = 4'd0;
    endcase
  endfunction

  assign sample     = (div_cnt_reg == DW'(SCAN_DIV - 1));
  assign row_onehot = (row_sense != '0) && ((row_sense & (row_sense - ROWS'(1))) == '0);

  always_comb begin
    row_index = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (row_sense[i]) row_index = RIW'(i);
    end
  end

  // Decode works on the captured coordinates, which are stable from capture on.
  always_comb begin
    decoded = '0;
    if (BASE == 10) decoded = VW'(phone_map(int'(row_idx_reg) * 4 + int'(col_idx_reg)));
    else            decoded = VW'(int'(row_idx_reg) * COLS + int'(col_idx_reg));
  end

  always_comb begin
    state_next       = state_reg;
    div_cnt_next     = sample ? '0 : div_cnt_reg + DW'(1);
    col_drive_next   = col_drive_reg;
    col_idx_next     = col_idx_reg;
    row_pat_next     = row_pat_reg;
    row_idx_next     = row_idx_reg;
    deb_cnt_next     = deb_cnt_reg;
    rep_cnt_next     = rep_cnt_reg;
    rep_armed_next   = rep_armed_reg;
    key_value_next   = key_value_reg;
    key_held_next    = key_held_reg;
    key_valid_next   = 1'b0;
    key_release_next = 1'b0;
    rotate           = 1'b0;
    accept           = 1'b0;
    repeat_fire      = 1'b0;
    release_done     = 1'b0;

    case (state_reg)
      ST_SCAN: begin
        if (sample) begin
          if (row_onehot) begin
            row_pat_next = row_sense;
            row_idx_next = row_index;
            deb_cnt_next = MW'(1);
            state_next   = ST_DEBOUNCE;
          end else begin
            rotate = 1'b1;
          end
        end
      end
      ST_DEBOUNCE: begin
        // Only reachable with DEBOUNCE=1: the capture itself completes the count.
        if (int'(deb_cnt_reg) >= DEBOUNCE) begin
          accept = 1'b1;
        end else if (sample) begin
          if (row_sense == row_pat_reg) begin
            if (int'(deb_cnt_reg) + 1 >= DEBOUNCE) accept = 1'b1;
            else deb_cnt_next = deb_cnt_reg + MW'(1);
          end else begin
            state_next = ST_SCAN;
            rotate     = 1'b1;
          end
        end
      end
      ST_PRESSED: begin
        if (sample) begin
          if (row_sense == '0) begin
            state_next   = ST_RELEASE;
            deb_cnt_next = MW'(1);
          end else if (REPEAT_DLY > 0) begin
            if (!rep_armed_reg) begin
              if (int'(rep_cnt_reg) + 1 >= REPEAT_DLY) begin
                repeat_fire    = 1'b1;
                rep_armed_next = 1'b1;
                rep_cnt_next   = '0;
              end else begin
                rep_cnt_next = rep_cnt_reg + RW'(1);
              end
            end else if (int'(rep_cnt_reg) + 1 >= REPEAT_RATE) begin
              repeat_fire  = 1'b1;
              rep_cnt_next = '0;
            end else begin
              rep_cnt_next = rep_cnt_reg + RW'(1);
            end
          end
        end
      end
      ST_RELEASE: begin
        if (int'(deb_cnt_reg) >= DEBOUNCE) begin
          release_done = 1'b1;
        end else if (sample) begin
          if (row_sense == '0) begin
            if (int'(deb_cnt_reg) + 1 >= DEBOUNCE) release_done = 1'b1;
            else deb_cnt_next = deb_cnt_reg + MW'(1);
          end else begin
            state_next     = ST_PRESSED;
            rep_cnt_next   = '0;
            rep_armed_next = 1'b0;
          end
        end
      end
      default: state_next = ST_SCAN;
    endcase

    if (accept) begin
      state_next     = ST_PRESSED;
      key_held_next  = 1'b1;
      rep_cnt_next   = '0;
      rep_armed_next = 1'b0;
      if (DEC_OK) begin
        key_valid_next = 1'b1;
        key_value_next = decoded;
      end
    end
    if (repeat_fire && DEC_OK) key_valid_next = 1'b1;
    if (release_done) begin
      state_next       = ST_SCAN;
      key_held_next    = 1'b0;
      key_release_next = 1'b1;
      rotate           = 1'b1;
    end
    if (rotate) begin
      col_drive_next = {col_drive_reg[COLS-2:0], col_drive_reg[COLS-1]};
      col_idx_next   = (col_idx_reg == CIW'(COLS - 1)) ? '0 : col_idx_reg + CIW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_SCAN;
      div_cnt_reg     <= '0;
      col_drive_reg   <= COLS'(1);
      col_idx_reg     <= '0;
      row_pat_reg     <= '0;
      row_idx_reg     <= '0;
      deb_cnt_reg     <= '0;
      rep_cnt_reg     <= '0;
      rep_armed_reg   <= 1'b0;
      key_value_reg   <= '0;
      key_valid_reg   <= 1'b0;
      key_held_reg    <= 1'b0;
      key_release_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      div_cnt_reg     <= div_cnt_next;
      col_drive_reg   <= col_drive_next;
      col_idx_reg     <= col_idx_next;
      row_pat_reg     <= row_pat_next;
      row_idx_reg     <= row_idx_next;
      deb_cnt_reg     <= deb_cnt_next;
      rep_cnt_reg     <= rep_cnt_next;
      rep_armed_reg   <= rep_armed_next;
      key_value_reg   <= key_value_next;
      key_valid_reg   <= key_valid_next;
      key_held_reg    <= key_held_next;
      key_release_reg <= key_release_next;
    end
  end

  assign col_drive   = col_drive_reg;
  assign key_value   = key_value_reg;
  assign key_valid   = key_valid_reg;
  assign key_held    = key_held_reg;
  assign key_release = key_release_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench: dut_a is linear decode with auto-repeat, dut_b is telephone decode.
module tb_keypad_scanner;

  localparam int EV_VALID = 0;
  localparam int EV_REL   = 1;

  typedef struct {
    int kind;
    int value;
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_a = '0, row_b = '0;
  logic [3:0] col_a, col_b, val_a, val_b;
  logic       valid_a, valid_b, held_a, held_b, rel_a, rel_b;

  int total = 0;
  int bad   = 0;
  int ecnt  = 0;
  ev_t qa[$];
  ev_t qb[$];

  always #5 clk = ~clk;

  keypad_scanner #(
    .ROWS(4), .COLS(4), .BASE(16), .SCAN_DIV(4), .DEBOUNCE(3),
    .REPEAT_DLY(5), .REPEAT_RATE(2)
  ) dut_a (
    .clk(clk), .rst(rst), .row_sense(row_a), .col_drive(col_a),
    .key_value(val_a), .key_valid(valid_a), .key_held(held_a), .key_release(rel_a)
  );

  keypad_scanner #(
    .ROWS(4), .COLS(4), .BASE(10), .SCAN_DIV(4), .DEBOUNCE(3),
    .REPEAT_DLY(0), .REPEAT_RATE(4)
  ) dut_b (
    .clk(clk), .rst(rst), .row_sense(row_b), .col_drive(col_b),
    .key_value(val_b), .key_valid(valid_b), .key_held(held_b), .key_release(rel_b)
  );

  // Edges since reset deassertion; expected event times are expressed in these.
  always @(posedge clk or posedge rst) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, ecnt);
    end
  endtask

  task automatic wait_edge(input int k);
    while (ecnt < k) @(negedge clk);
  endtask

  task automatic push(input int d, input int kind, input int value, input int cyc);
    ev_t e;
    e.kind = kind; e.value = value; e.cyc = cyc;
    if (d == 0) qa.push_back(e);
    else        qb.push_back(e);
  endtask

  task automatic mon(input int d, input logic v, input logic r, input logic [3:0] val);
    ev_t e;
    chk($sformatf("dut%0d_valid_release_overlap", d), {31'd0, v & r}, 0);
    if (v || r) begin
      $display("dut%0d %s value=%0d edge=%0d", d, v ? "key_valid" : "key_release", val, ecnt);
      if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
        total++;
        bad++;
        $display("FAIL dut%0d_unexpected_pulse: got pulse at edge %0d expected none", d, ecnt);
      end else begin
        e = (d == 0) ? qa.pop_front() : qb.pop_front();
        chk($sformatf("dut%0d_event_kind", d), v ? EV_VALID : EV_REL, e.kind);
        chk($sformatf("dut%0d_event_edge", d), ecnt, e.cyc);
        if (v) chk($sformatf("dut%0d_event_value", d), {28'd0, val}, e.value);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, valid_a, rel_a, val_a);
      mon(1, valid_b, rel_b, val_b);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic stim_a();
    for (int k = 1; k <= 17; k++) begin
      wait_edge(k);
      chk("a_free_scan_col", {28'd0, col_a}, 1 << ((k / 4) % 4));
    end
    // Key at row 2, column 1 -> 9
    wait_edge(20); row_a = 4'b0100; push(0, EV_VALID, 9, 32);
    wait_edge(31); chk("a_held_before_accept", {31'd0, held_a}, 0);
    chk("a_col_frozen", {28'd0, col_a}, 4'b0010);
    wait_edge(32); chk("a_held_after_accept", {31'd0, held_a}, 1);
    chk("a_value_9", {28'd0, val_a}, 9);
    wait_edge(41); row_a = 4'b0000; push(0, EV_REL, 0, 52);
    wait_edge(51); chk("a_held_during_release", {31'd0, held_a}, 1);
    wait_edge(52); chk("a_held_after_release", {31'd0, held_a}, 0);
    chk("a_resume_col2", {28'd0, col_a}, 4'b0100);
    chk("a_value_kept", {28'd0, val_a}, 9);
    // Bounce: capture, mismatch, then a clean press at row 1, column 3 -> 7
    wait_edge(53); row_a = 4'b0010;
    wait_edge(57); row_a = 4'b0000;
    wait_edge(60); chk("a_bounce_rotates", {28'd0, col_a}, 4'b1000);
    chk("a_bounce_not_held", {31'd0, held_a}, 0);
    wait_edge(61); row_a = 4'b0010; push(0, EV_VALID, 7, 72);
    wait_edge(73); row_a = 4'b0000; chk("a_held_7", {31'd0, held_a}, 1);
    wait_edge(77); row_a = 4'b0010;
    wait_edge(81); row_a = 4'b0000; push(0, EV_REL, 0, 92);
    wait_edge(89); chk("a_held_after_rebounce", {31'd0, held_a}, 1);
    wait_edge(92); chk("a_released_2", {31'd0, held_a}, 0);
    chk("a_resume_col0", {28'd0, col_a}, 4'b0001);
    // Auto-repeat: row 3, column 1 -> 13, repeats at pressed samples 5, 7, 9
    wait_edge(97); row_a = 4'b1000;
    push(0, EV_VALID, 13, 108);
    push(0, EV_VALID, 13, 128);
    push(0, EV_VALID, 13, 136);
    push(0, EV_VALID, 13, 144);
    wait_edge(120); chk("a_repeat_held", {31'd0, held_a}, 1);
    chk("a_repeat_col", {28'd0, col_a}, 4'b0010);
    chk("a_repeat_value", {28'd0, val_a}, 13);
    wait_edge(146);
    rst = 1'b1;
    #1;
    chk("a_rst_col", {28'd0, col_a}, 1);
    chk("a_rst_value", {28'd0, val_a}, 0);
    chk("a_rst_valid", {31'd0, valid_a}, 0);
    chk("a_rst_held", {31'd0, held_a}, 0);
    chk("a_rst_release", {31'd0, rel_a}, 0);
    row_a = 4'b0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_edge(3); chk("a_restart_col0", {28'd0, col_a}, 4'b0001);
    wait_edge(4); chk("a_restart_col1", {28'd0, col_a}, 4'b0010);
    wait_edge(20); chk("a_restart_not_held", {31'd0, held_a}, 0);
  endtask

  task automatic stim_b();
    wait_edge(1);  row_b = 4'b0011;
    wait_edge(4);  chk("b_ghost_col1", {28'd0, col_b}, 4'b0010);
    wait_edge(8);  chk("b_ghost_col2", {28'd0, col_b}, 4'b0100);
    wait_edge(9);  row_b = 4'b0000;
    wait_edge(16); chk("b_scan_col0", {28'd0, col_b}, 4'b0001);
    chk("b_ghost_not_held", {31'd0, held_b}, 0);
    // Row 3, column 0 -> 14 on the telephone map
    wait_edge(17); row_b = 4'b1000; push(1, EV_VALID, 14, 28);
    wait_edge(28); chk("b_held", {31'd0, held_b}, 1);
    chk("b_value_14", {28'd0, val_b}, 14);
    wait_edge(29); row_b = 4'b0000; push(1, EV_REL, 0, 40);
    wait_edge(40); chk("b_released", {31'd0, held_b}, 0);
    chk("b_resume_col1", {28'd0, col_b}, 4'b0010);
    // Multi-hot during debounce aborts the capture
    wait_edge(49); row_b = 4'b0001;
    wait_edge(53); chk("b_capture_frozen", {28'd0, col_b}, 4'b1000);
    row_b = 4'b0011;
    wait_edge(56); chk("b_ghost_abort_col", {28'd0, col_b}, 4'b0001);
    chk("b_ghost_abort_held", {31'd0, held_b}, 0);
    wait_edge(57); row_b = 4'b0000;
    // Row 0, column 1 -> 2
    wait_edge(61); row_b = 4'b0001; push(1, EV_VALID, 2, 72);
    wait_edge(72); chk("b_value_2", {28'd0, val_b}, 2);
    wait_edge(73); row_b = 4'b0000; push(1, EV_REL, 0, 84);
    wait_edge(84); chk("b_released_2", {31'd0, held_b}, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_col", {28'd0, col_a}, 1);
    chk("rst_value", {28'd0, val_a}, 0);
    chk("rst_valid", {31'd0, valid_a}, 0);
    chk("rst_held", {31'd0, held_a}, 0);
    chk("rst_release", {31'd0, rel_a}, 0);
    rst = 1'b0;
    fork
      stim_a();
      stim_b();
    join
    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
